// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        TRAP    = 2'd2,
        HANDLER = 2'd3
    } irq_state_t;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam logic [1:0] TADDR_CMP_LO  = 2'd0;
    localparam logic [1:0] TADDR_CMP_HI  = 2'd1;
    localparam logic [1:0] TADDR_TIME_LO = 2'd2;
    localparam logic [1:0] TADDR_TIME_HI = 2'd3;

    localparam int MEIP_BIT = 11;
    localparam int MTIP_BIT = 7;

endpackage

// File: rtl/irq_ctrl_mtimer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp, register access and mtip compare.
module irq_ctrl_mtimer
    import irq_pkg::*;
#(
    parameter int TIMER_PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_we,
    input  logic [1:0]  timer_addr,
    input  logic [31:0] timer_wdata,
    output logic [31:0] timer_rdata,
    output logic        mtip
);

    localparam int PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [63:0]   mtime_q;
    logic [63:0]   mtimecmp_q;
    logic          tick;

    assign tick = (presc_q == PRESC_MAX);

    // A software write to either mtime half suppresses that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (timer_we && timer_addr == TADDR_CMP_LO) mtimecmp_q[31:0]  <= timer_wdata;
            if (timer_we && timer_addr == TADDR_CMP_HI) mtimecmp_q[63:32] <= timer_wdata;
            if (timer_we && timer_addr == TADDR_TIME_LO) begin
                mtime_q[31:0] <= timer_wdata;
            end else if (timer_we && timer_addr == TADDR_TIME_HI) begin
                mtime_q[63:32] <= timer_wdata;
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
        end
    end

    always_comb begin
        timer_rdata = '0;
        case (timer_addr)
            TADDR_CMP_LO:  timer_rdata = mtimecmp_q[31:0];
            TADDR_CMP_HI:  timer_rdata = mtimecmp_q[63:32];
            TADDR_TIME_LO: timer_rdata = mtime_q[31:0];
            TADDR_TIME_HI: timer_rdata = mtime_q[63:32];
            default:       timer_rdata = '0;
        endcase
    end

    assign mtip = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: external line synchroniser, timer, enable gating
// and the trap sequencing FSM feeding the CSR file and PC mux.
//
// state   | meaning
// IDLE    | no enabled request
// PEND    | request seen, waiting for an unstalled valid instruction
// TRAP    | one-cycle trap pulse, trap_pc/mcause already captured
// HANDLER | in handler, no nesting until MRET
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC       = 32'h0000_0100,
    parameter int          TIMER_PRESCALE = 1,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        inst_valid,
    input  logic        stall,
    input  logic        is_mret,
    input  logic [31:0] pc,
    input  logic        timer_we,
    input  logic [1:0]  timer_addr,
    input  logic [31:0] timer_wdata,
    output logic [31:0] timer_rdata,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [31:0] mcause,
    output logic [31:0] trap_vec,
    output logic [31:0] mip_out
);

    irq_state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   meip, mtip;
    logic                   req_ext, req_tmr, req;
    logic                   capture;

    irq_ctrl_mtimer #(
        .TIMER_PRESCALE(TIMER_PRESCALE)
    ) u_mtimer (
        .clk        (clk),
        .rst        (rst),
        .timer_we   (timer_we),
        .timer_addr (timer_addr),
        .timer_wdata(timer_wdata),
        .timer_rdata(timer_rdata),
        .mtip       (mtip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq};
    end

    assign meip    = sync_q[SYNC_STAGES-1];
    assign req_ext = meip & mie_meie;
    assign req_tmr = mtip & mie_mtie;
    assign req     = mstatus_mie & (req_ext | req_tmr);
    assign capture = (state_q == PEND) & req & inst_valid & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = PEND;
            PEND: begin
                if (!req)         state_d = IDLE;
                else if (capture) state_d = TRAP;
            end
            TRAP:    state_d = HANDLER;
            HANDLER: if (is_mret) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // External takes priority when both sources are requesting on the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_pc <= '0;
            mcause  <= '0;
        end else if (capture) begin
            trap_pc <= pc;
            mcause  <= req_ext ? CAUSE_MEI : CAUSE_MTI;
        end
    end

    assign trap     = (state_q == TRAP);
    assign trap_vec = TRAP_VEC;

    always_comb begin
        mip_out           = '0;
        mip_out[MEIP_BIT] = meip;
        mip_out[MTIP_BIT] = mtip;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-mode interrupt controller directly upstream of the CSR register file.
- Owns the machine timer (mtime/mtimecmp) and synchronises the external interrupt line.
- Gates both sources with the mstatus.MIE/mie enables that the CSR file supplies, and fires a one-cycle trap at an instruction boundary.
- The CSR file consumes trap, trap_pc, mcause and mip_out. The PC mux consumes trap and trap_vec.

Parameters:
- TRAP_VEC, 32'h0000_0100, handler address driven on trap_vec.
- TIMER_PRESCALE, 1, clk cycles per mtime increment (>=1).
- SYNC_STAGES, 2, flops on ext_irq (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ext_irq  in  1  external interrupt, level, asynchronous to clk
- mstatus_mie  in  1  global enable (mstatus[3]) from CSR file
- mie_meie  in  1  external enable (mie[11])
- mie_mtie  in  1  timer enable (mie[7])
- inst_valid  in  1  instruction in execute is valid
- stall  in  1  pipeline stalled this cycle
- is_mret  in  1  MRET executing this cycle
- pc  in  32  PC of instruction in execute
- timer_we  in  1  timer register write strobe
- timer_addr  in  2  0=mtimecmp lo, 1=mtimecmp hi, 2=mtime lo, 3=mtime hi
- timer_wdata  in  32  timer write data
- timer_rdata  out  32  timer read data, combinational on timer_addr
- trap  out  1  one-cycle trap pulse
- trap_pc  out  32  PC to save into mepc
- mcause  out  32  cause value for the CSR file
- trap_vec  out  32  handler target; constant TRAP_VEC
- mip_out  out  32  pending bits: [11]=meip, [7]=mtip, others 0

Behaviour:
Reset (async, immediate):
- Outputs: trap=0, trap_pc=0, mcause=0.
- State: FSM=IDLE, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, sync flops=0.
- Reset during PEND, TRAP or HANDLER returns to IDLE. No trap is emitted.

Timer:
- Prescaler counts 0..TIMER_PRESCALE-1. On the wrap, mtime increments by 1.
- mtime is 64-bit and wraps from all-ones to 0.
- A write to mtime lo/hi replaces that half. The write wins over an increment in the same cycle; the increment is dropped that cycle.
- Each write touches one 32-bit half only. There is no carry between halves on write.
- mtip = (mtime >= mtimecmp), unsigned 64-bit, combinational from the registers.
- A write to mtimecmp updates mtip in the following cycle.

External:
- meip = last stage of the SYNC_STAGES synchroniser. Latency is SYNC_STAGES cycles.
- Level-sensitive. No latching.

Request and priority:
- req_ext = meip & mie_meie
- req_tmr = mtip & mie_mtie
- req = mstatus_mie & (req_ext | req_tmr)
- External wins: mcause = 32'h8000_000B for external, 32'h8000_0007 for timer.

FSM:
- IDLE: if req, go to PEND.
- PEND:
  - If !req, go back to IDLE. A source that drops is not trapped.
  - Else if inst_valid & !stall, go to TRAP. On that edge, register trap_pc <= pc and mcause from the priority encode.
- TRAP: trap=1 for exactly this cycle. Unconditionally go to HANDLER.
- HANDLER:
  - No new trap regardless of req (no nesting).
  - is_mret goes to IDLE. If req is still high, PEND is reached on the next edge, so the earliest next trap is 3 cycles after the MRET cycle.
- is_mret outside HANDLER is ignored.

Timing:
- Latency from boundary cycle to trap pulse is 1 cycle.
- trap_pc and mcause hold their values until the next trap.

Decomposition:
- Package irq_pkg:
  - state enum (IDLE, PEND, TRAP, HANDLER)
  - cause constants CAUSE_MEI=32'h8000_000B, CAUSE_MTI=32'h8000_0007
  - timer address constants
  - mip bit positions (MEIP=11, MTIP=7)
- One sub-module, mtimer: prescaler, mtime/mtimecmp registers, write/read decode, mtip compare.
- Synchroniser and FSM stay in irq_ctrl.

Test Plan:
1. Reset then idle for 10 cycles -> trap=0, mip_out=0, timer_rdata(addr 2)=10 (PRESCALE=1).
2. Write mtimecmp={0,20}, mie_mtie=1, mstatus_mie=1, inst_valid=1, stall=0, pc=32'h40 -> single trap pulse after mtime reaches 20, trap_pc=32'h40, mcause=32'h8000_0007, trap_vec=32'h100.
3. ext_irq=1 and timer pending together, both enabled -> mcause=32'h8000_000B. meip visible in mip_out[11] exactly 2 cycles after ext_irq rises.
4. Request pending with stall=1 for 5 cycles -> no trap. trap fires the cycle after stall falls, trap_pc = pc from the non-stalled cycle. Repeat with the enable dropped during the stall -> FSM returns to IDLE, no trap.
5. In HANDLER with req held -> no second trap. Pulse is_mret -> next trap exactly 3 cycles later.
6. Write mtime hi/lo = 32'hFFFF_FFFF -> next increment wraps mtime to 0. Assert rst mid-PEND -> trap stays 0 and mtimecmp reads back all-ones.
